// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//
// Multi-cycle signed/unsigned-low integer multiplier for the execute stage.
// It accepts the decoded ALU control codes for mul (5'b01001, low word of
// the product) and mulh (5'b01010, high word of the signed x signed product).
// The datapath is iterative shift-add on operand magnitudes. It consumes
// BITS_PER_CYCLE multiplier bits per clock, so an operation takes
// N = WIDTH/BITS_PER_CYCLE cycles. The sign is applied once, at the end.
//
// Optional feature macro: MUL_ZERO_BYPASS_EN
//   When this macro is defined, an operation with a zero operand skips the
//   iteration and presents its (zero) result one cycle after accept.
//   When it is undefined, every operation takes the full N cycles.
//
// Parameters:
//   BITS_PER_CYCLE  multiplier bits consumed per iteration (1, 2, 4 or 8)
//   WIDTH           operand/result width (only 32 is supported)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   req         in   operation request from execute
//   alucontrol  in   [4:0] decoded ALU control code
//   srca        in   [31:0] multiplicand (rs1)
//   srcb        in   [31:0] multiplier (rs2)
//   ready       out  unit idle, a request can be accepted
//   flush       in   cancel any in-flight operation
//   res_valid   out  result available
//   res_ready   in   consumer takes the result
//   result      out  [31:0] product word, zero while res_valid is low
// -----------------------------------------------------------------------------
module mul_unit #(
  parameter int BITS_PER_CYCLE = 2,
  parameter int WIDTH          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             ready,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam logic [5:0] N_ITER = 6'(WIDTH / BITS_PER_CYCLE);
  localparam logic [4:0] CODE_MUL  = 5'b01001;
  localparam logic [4:0] CODE_MULH = 5'b01010;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude. The most negative value maps to itself,
  // and that is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = (~v) + ONE_W;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Sum of the multiplicand shifted by each set bit of one multiplier chunk.
  function automatic logic [PW-1:0] partial_product(input logic [PW-1:0] mcand_in,
                                                    input logic [BITS_PER_CYCLE-1:0] bits);
    logic [PW-1:0] pp;
    pp = {PW{1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (bits[i]) begin
        pp = pp + (mcand_in << i);
      end else begin
        pp = pp;
      end
    end
    return pp;
  endfunction

  // Apply the product sign to the unsigned accumulator.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg_in);
    logic [PW-1:0] p;
    if (neg_in) begin
      p = (~v) + ONE_P;
    end else begin
      p = v;
    end
    return p;
  endfunction

  state_t             state, state_n;
  logic               op, op_n;
  logic               neg, neg_n;
  logic [5:0]         count, count_n;
  logic [PW-1:0]      mcand, mcand_n;     // |srca|, shifted left each iteration
  logic [WIDTH-1:0]   mplier, mplier_n;   // |srcb|, shifted right each iteration
  logic [PW-1:0]      acc, acc_n;
  logic               ready_n;
  logic               res_valid_n;
  logic [WIDTH-1:0]   result_n;
  logic [PW-1:0]      signed_prod;
  logic               is_mul_code;
  logic               accept;
  logic               zero_op;

  assign is_mul_code = (alucontrol == CODE_MUL) || (alucontrol == CODE_MULH);
  // flush wins over a simultaneous request in IDLE.
  assign accept      = (state == IDLE) && req && !flush && is_mul_code;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (srca == {WIDTH{1'b0}}) || (srcb == {WIDTH{1'b0}});
`else
  assign zero_op = 1'b0;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_n     = state;
    op_n        = op;
    neg_n       = neg;
    count_n     = count;
    mcand_n     = mcand;
    mplier_n    = mplier;
    acc_n       = acc;
    ready_n     = ready;
    res_valid_n = res_valid;
    result_n    = result;
    signed_prod = {PW{1'b0}};

    case (state)
      IDLE: begin
        if (accept) begin
          op_n        = (alucontrol == CODE_MULH);
          mcand_n     = {{WIDTH{1'b0}}, magnitude(srca)};
          mplier_n    = magnitude(srcb);
          count_n     = N_ITER;
          acc_n       = {PW{1'b0}};
          ready_n     = 1'b0;
          if (zero_op) begin
            // The product is zero, so the sign cannot matter.
            neg_n       = 1'b0;
            state_n     = DONE;
            res_valid_n = 1'b1;
            result_n    = {WIDTH{1'b0}};
          end else begin
            neg_n       = srca[WIDTH-1] ^ srcb[WIDTH-1];
            state_n     = CALC;
            res_valid_n = 1'b0;
            result_n    = {WIDTH{1'b0}};
          end
        end else begin
          ready_n     = 1'b1;
          res_valid_n = 1'b0;
          result_n    = {WIDTH{1'b0}};
        end
      end

      CALC: begin
        if (flush) begin
          state_n     = IDLE;
          ready_n     = 1'b1;
          res_valid_n = 1'b0;
          result_n    = {WIDTH{1'b0}};
        end else begin
          acc_n    = acc + partial_product(mcand, mplier[BITS_PER_CYCLE-1:0]);
          mcand_n  = mcand << BITS_PER_CYCLE;
          mplier_n = mplier >> BITS_PER_CYCLE;
          count_n  = count - 6'd1;
          if (count == 6'd1) begin
            // The last chunk is folded in on this edge, so sign the updated sum.
            signed_prod = apply_sign(acc_n, neg);
            state_n     = DONE;
            res_valid_n = 1'b1;
            if (op) begin
              result_n = signed_prod[PW-1:WIDTH];
            end else begin
              result_n = signed_prod[WIDTH-1:0];
            end
          end else begin
            state_n     = CALC;
            res_valid_n = 1'b0;
            result_n    = {WIDTH{1'b0}};
          end
        end
      end

      DONE: begin
        if (flush || res_ready) begin
          state_n     = IDLE;
          ready_n     = 1'b1;
          res_valid_n = 1'b0;
          result_n    = {WIDTH{1'b0}};
        end else begin
          state_n     = DONE;
          ready_n     = 1'b0;
          res_valid_n = 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        ready_n     = 1'b1;
        res_valid_n = 1'b0;
        result_n    = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 1'b0;
      neg       <= 1'b0;
      count     <= 6'd0;
      mcand     <= {PW{1'b0}};
      mplier    <= {WIDTH{1'b0}};
      acc       <= {PW{1'b0}};
      ready     <= 1'b1;
      res_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
    end else begin
      state     <= state_n;
      op        <= op_n;
      neg       <= neg_n;
      count     <= count_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      acc       <= acc_n;
      ready     <= ready_n;
      res_valid <= res_valid_n;
      result    <= result_n;
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
//
// Self-checking bench for mul_unit. A cycle-level behavioural model computes
// the product with plain 64-bit signed arithmetic and tracks the remaining
// latency as a countdown. A compare process checks ready, res_valid and
// result against that model on every falling edge. Directed operations pin
// the model and the DUT to hand-computed values. Randomized traffic then
// exercises the handshake, flush and operand corner cases.
// -----------------------------------------------------------------------------
module tb_mul_unit;

  localparam int BPC = 2;
  localparam int N   = 32 / BPC;
  localparam logic [4:0] C_MUL  = 5'b01001;
  localparam logic [4:0] C_MULH = 5'b01010;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [4:0]  alucontrol = 5'd0;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        ready;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mul_unit #(.BITS_PER_CYCLE(BPC), .WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .ready      (ready),
    .flush      (flush),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Reference product: full 64-bit signed product, with the low or high word selected.
  function automatic logic [31:0] ref_mul(input logic high, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    p = longint'($signed(a)) * longint'($signed(b));
    u = p;
    return high ? u[63:32] : u[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  int          m_left = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_result = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_left   <= 0;
      m_result <= 32'd0;
    end else if (m_valid) begin
      if (flush || res_ready) begin
        m_valid  <= 1'b0;
        m_result <= 32'd0;
      end
    end else if (m_busy) begin
      if (flush) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_valid  <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (req && !flush && (alucontrol == C_MUL || alucontrol == C_MULH)) begin
      if (BYPASS && (srca == 32'd0 || srcb == 32'd0)) begin
        m_valid  <= 1'b1;
        m_result <= 32'd0;
      end else begin
        m_busy <= 1'b1;
        m_left <= N;
        m_pend <= ref_mul(alucontrol == C_MULH, srca, srcb);
      end
    end
  end

  // Compare process: on every falling edge, check the DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {31'd0, ready}, {31'd0, !(m_busy || m_valid)});
      check("cyc_res_valid", {31'd0, res_valid}, {31'd0, m_valid});
      check("cyc_result", result, m_result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op. Check its latency (edges after the accept edge) and its result, then consume it.
  task automatic run_op(input string name, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    req = 1'b1; alucontrol = code; srca = a; srcb = b;
    step();
    req = 1'b0; alucontrol = 5'($urandom); srca = $urandom; srcb = $urandom;
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(exp_lat));
    check({name, "_result"}, result, exp);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    // Pin the reference model to hand-computed values.
    check("model_mul_7x6", ref_mul(1'b0, 32'd7, 32'd6), 32'h0000_002A);
    check("model_mul_neg3x5", ref_mul(1'b0, 32'hFFFF_FFFD, 32'd5), 32'hFFFF_FFF1);
    check("model_mulh_min", ref_mul(1'b1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("model_mulh_m1", ref_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);

    repeat (3) step();
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    run_op("mul_7x6", C_MUL, 32'd7, 32'd6, 32'h0000_002A, N);
    run_op("mul_neg3x5", C_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, N);
    run_op("mulh_min", C_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, N);
    run_op("mulh_m1", C_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, N);
    run_op("mul_zero", C_MUL, 32'd0, 32'h1234, 32'd0, BYPASS ? 0 : N);

    // An unsupported code must be ignored.
    req = 1'b1; alucontrol = 5'b00011; srca = 32'd9; srcb = 32'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ignored_code_ready", {31'd0, ready}, 32'd1);
    end
    req = 1'b0;

    // Flush during the 8th CALC cycle.
    req = 1'b1; alucontrol = C_MUL; srca = 32'd11; srcb = 32'd13;
    step();
    req = 1'b0;
    repeat (7) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_res_valid", {31'd0, res_valid}, 32'd0);
    k = 0;
    for (int i = 0; i < N + 4; i++) begin
      step();
      if (res_valid === 1'b1) k++;
    end
    check("flush_no_result", 32'(k), 32'd0);

    // Back-pressure: hold the result, with a pending request that must wait.
    req = 1'b1; alucontrol = C_MUL; srca = 32'h1234; srcb = 32'h10;
    step();
    req = 1'b0;
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check("bp_latency", 32'(k), 32'(N));
    req = 1'b1; alucontrol = C_MUL; srca = 32'd2; srcb = 32'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_result", result, 32'h0001_2340);
      check("bp_hold_ready", {31'd0, ready}, 32'd0);
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_release_valid", {31'd0, res_valid}, 32'd0);
    check("bp_release_ready", {31'd0, ready}, 32'd1);
    step();
    req = 1'b0;
    check("bp_next_accept", {31'd0, ready}, 32'd0);
    k = 0;
    while (res_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check("bp_next_result", result, 32'd6);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Asynchronous reset in the middle of CALC, applied between edges.
    req = 1'b1; alucontrol = C_MULH; srca = 32'hDEAD_BEEF; srcb = 32'h1234_5678;
    step();
    req = 1'b0;
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ready", {31'd0, ready}, 32'd1);
    check("async_reset_valid", {31'd0, res_valid}, 32'd0);
    check("async_reset_result", result, 32'd0);
    step();
    reset = 1'b0;
    step();
    run_op("mul_3x3", C_MUL, 32'd3, 32'd3, 32'd9, N);

    // Randomized traffic, checked cycle by cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: alucontrol = C_MUL;
        1: alucontrol = C_MULH;
        2: alucontrol = 5'($urandom);
        default: alucontrol = C_MUL;
      endcase
      srca = pick_operand();
      srcb = pick_operand();
      flush = ($urandom_range(0, 24) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    req = 1'b0; flush = 1'b1; res_ready = 1'b0;
    step();
    flush = 1'b0;
    step();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
